ign_conditioner: RTL
====================

IGN_CONDITIONER -- requirements
Module: ign_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, SHALL set the consecutive stable cycles required to accept a level change (legal range 2..2^20); 50000 is 1 ms at 50 MHz.
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set the synchronizer depth (legal range 2..3).
REQ-003 clk  input  1  SHALL be the single system clock.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 ign_raw  input  1  SHALL be the asynchronous ignition sense pin from the board.
REQ-006 glitch_clr  input  1  SHALL be a synchronous clear of glitch_count, one-cycle strobe.
REQ-007 ign_out  output  1  SHALL be the debounced ignition level that drives the ignition PIO in_port.
REQ-008 ign_rise  output  1  SHALL be a one-cycle pulse on an accepted 0->1 change.
REQ-009 ign_fall  output  1  SHALL be a one-cycle pulse on an accepted 1->0 change.
REQ-010 glitch_count  output  8  SHALL be a saturating count of rejected transitions.

Function
REQ-011 ign_raw SHALL pass through a SYNC_STAGES flop chain; ign_sync is the last stage, and no other logic samples ign_raw.
REQ-012 The FSM SHALL have the states STABLE_LOW, CHECK_HIGH, STABLE_HIGH and CHECK_LOW.
REQ-013 In STABLE_LOW with ign_sync=1, the FSM SHALL go to CHECK_HIGH and load cnt=1; in STABLE_HIGH with ign_sync=0, it SHALL go to CHECK_LOW and load cnt=1.
REQ-014 In CHECK_x, while ign_sync equals the candidate level and cnt<DEBOUNCE_CYCLES, cnt SHALL increment each cycle.
REQ-015 In CHECK_x, when ign_sync equals the candidate and cnt==DEBOUNCE_CYCLES, the next state SHALL be STABLE_x, ign_out SHALL take the candidate, and ign_rise or ign_fall SHALL assert for exactly that same cycle.
REQ-016 Latency SHALL be exactly DEBOUNCE_CYCLES clocks from the first ign_sync change to the ign_out change, and SYNC_STAGES+DEBOUNCE_CYCLES clocks from ign_raw.
REQ-017 In CHECK_x, if ign_sync reverts to the stable level, the FSM SHALL return to the prior STABLE state, cnt SHALL clear, ign_out SHALL be unchanged, no pulse SHALL assert, and glitch_count SHALL increment.
REQ-018 glitch_count SHALL saturate at 255 and never wrap.
REQ-019 glitch_clr SHALL zero glitch_count on the next edge and SHALL win over a simultaneous increment.
REQ-020 ign_rise and ign_fall SHALL never assert together and SHALL never assert on consecutive cycles.
REQ-021 The counter width SHALL be clog2(DEBOUNCE_CYCLES+1), and cnt SHALL never exceed DEBOUNCE_CYCLES.
REQ-022 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-023 Assertion of reset_n=0 SHALL immediately force the sync flops to 0, state to STABLE_LOW, cnt to 0, ign_out to 0, ign_rise and ign_fall to 0, and glitch_count to 0.
REQ-024 Reset during CHECK_x SHALL abort the check with no pulse and no glitch count.
REQ-025 After reset release with ign_raw=1, the block SHALL perform a normal rise acceptance with one ign_rise pulse and SHALL NOT mark ign_out=1 prematurely.

Structure
REQ-026 The state encoding, the default DEBOUNCE_CYCLES and SYNC_STAGES values, and the glitch-count width SHALL live in shared package ign_cond_pkg.
REQ-027 The synchronizer SHALL be the sub-module ign_sync (parameterised depth, reset to 0), instantiated once; the FSM, counter and glitch counter SHALL stay in ign_conditioner.

Verification (the bench uses DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
REQ-028 Reset, then ign_raw 0->1 held -> ign_out=1 and a one-cycle ign_rise exactly 6 clocks after the raw edge; glitch_count=0.
REQ-029 From STABLE_HIGH, ign_raw high->low held -> ign_fall pulse and ign_out=0 6 clocks later; no ign_rise.
REQ-030 ign_raw high for 3 clocks, then low -> ign_out stays 0, no pulses, glitch_count=1.
REQ-031 Apply 300 short glitches -> glitch_count=255; then glitch_clr coincident with a glitch -> glitch_count=0.
REQ-032 Assert reset_n=0 during CHECK_HIGH with cnt=3, release with ign_raw=1 -> all outputs 0 during reset; ign_rise 6 clocks after release; glitch_count=0.
REQ-033 Drive ign_raw randomly for 10k cycles -> the assertions of REQ-020 and REQ-021 hold, and each ign_out change coincides with exactly one matching pulse.

Source files
------------

// File: rtl/ign_cond_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ign_cond_pkg
// Purpose  : Shared definitions for the ignition-sense conditioner.
//            - debounce FSM state encoding
//            - default debounce length and synchronizer depth
//            - glitch counter width, saturation value and saturating increment
// Revision : 1.0 - initial release
// ============================================================================
package ign_cond_pkg;

    // 50000 cycles is 1 ms at 50 MHz.
    localparam int unsigned c_DEBOUNCE_CYCLES_DEF = 50000;
    localparam int unsigned c_SYNC_STAGES_DEF     = 2;

    localparam int unsigned            c_GLITCH_W   = 8;
    localparam logic [c_GLITCH_W-1:0]  c_GLITCH_MAX = '1;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        CHECK_HIGH  = 2'd1,
        STABLE_HIGH = 2'd2,
        CHECK_LOW   = 2'd3
    } state_t;

    // Holds at the maximum instead of wrapping back to zero.
    function automatic logic [c_GLITCH_W-1:0] sat_inc(input logic [c_GLITCH_W-1:0] v);
        return (v == c_GLITCH_MAX) ? v : v + c_GLITCH_W'(1);
    endfunction

endpackage : ign_cond_pkg
`default_nettype wire

// File: rtl/ign_sync.sv
`default_nettype none
// ============================================================================
// Module   : ign_sync
// Purpose  : Multi-flop synchronizer for a single asynchronous input.
//            All stages reset to 0.
// Ports    : clk      - system clock
//            reset_n  - asynchronous active-low reset
//            i_async  - asynchronous input
//            o_sync   - synchronized output (last stage)
// Params   : STAGES   - number of flops in the chain (2..3)
// Revision : 1.0 - initial release
// ============================================================================
module ign_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_async,
    output logic o_sync
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_chain[STAGES-1];

endmodule : ign_sync
`default_nettype wire

// File: rtl/ign_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : ign_conditioner
// Purpose  : Synchronizes and debounces the board ignition-sense pin.
//            A level change is accepted only after DEBOUNCE_CYCLES consecutive
//            samples at the new level; a premature reversion is counted as a
//            glitch in a saturating counter.
// Ports    : clk          - system clock
//            reset_n      - asynchronous active-low reset
//            ign_raw      - asynchronous ignition sense pin
//            glitch_clr   - one-cycle strobe, clears glitch_count
//            ign_out      - debounced ignition level (registered)
//            ign_rise     - one-cycle pulse on accepted 0->1 (registered)
//            ign_fall     - one-cycle pulse on accepted 1->0 (registered)
//            glitch_count - saturating count of rejected transitions
// Params   : DEBOUNCE_CYCLES - stable samples needed to accept (2..2^20)
//            SYNC_STAGES     - synchronizer depth (2..3)
// Revision : 1.0 - initial release
// ============================================================================
module ign_conditioner
    import ign_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES_DEF,
    parameter int unsigned SYNC_STAGES     = c_SYNC_STAGES_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ign_raw,
    input  logic                  glitch_clr,
    output logic                  ign_out,
    output logic                  ign_rise,
    output logic                  ign_fall,
    output logic [c_GLITCH_W-1:0] glitch_count
);

    localparam int unsigned         c_CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE = c_CNT_W'(1);

    logic                  w_ign_sync;
    logic [c_CNT_W-1:0]    w_cnt_inc;
    logic                  w_glitch_ev;

    state_t                r_state;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_out;
    logic                  r_rise;
    logic                  r_fall;
    logic [c_GLITCH_W-1:0] r_glitch;

    // The synchronizer is the only consumer of the raw pin.
    ign_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_async (ign_raw),
        .o_sync  (w_ign_sync)
    );

    // r_cnt holds the number of candidate-level samples already seen in the
    // current check; the sample on this edge makes it r_cnt+1. Acceptance
    // happens on the edge where that running total reaches DEBOUNCE_CYCLES,
    // which puts the ign_out change exactly DEBOUNCE_CYCLES clocks after the
    // first changed synchronized sample. r_cnt is cleared on acceptance, so
    // it never exceeds DEBOUNCE_CYCLES.
    assign w_cnt_inc = r_cnt + c_CNT_ONE;

    // A check that sees the stable level again is a rejected transition.
    assign w_glitch_ev = ((r_state == CHECK_HIGH) && !w_ign_sync) ||
                         ((r_state == CHECK_LOW)  &&  w_ign_sync);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= STABLE_LOW;
            r_cnt   <= '0;
            r_out   <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                STABLE_LOW: begin
                    if (w_ign_sync) begin
                        r_state <= CHECK_HIGH;
                        r_cnt   <= c_CNT_ONE;
                    end
                end
                CHECK_HIGH: begin
                    if (!w_ign_sync) begin
                        r_state <= STABLE_LOW;
                        r_cnt   <= '0;
                    end else if (w_cnt_inc == c_CNT_MAX) begin
                        r_state <= STABLE_HIGH;
                        r_cnt   <= '0;
                        r_out   <= 1'b1;
                        r_rise  <= 1'b1;
                    end else begin
                        r_cnt   <= w_cnt_inc;
                    end
                end
                STABLE_HIGH: begin
                    if (!w_ign_sync) begin
                        r_state <= CHECK_LOW;
                        r_cnt   <= c_CNT_ONE;
                    end
                end
                CHECK_LOW: begin
                    if (w_ign_sync) begin
                        r_state <= STABLE_HIGH;
                        r_cnt   <= '0;
                    end else if (w_cnt_inc == c_CNT_MAX) begin
                        r_state <= STABLE_LOW;
                        r_cnt   <= '0;
                        r_out   <= 1'b0;
                        r_fall  <= 1'b1;
                    end else begin
                        r_cnt   <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state <= STABLE_LOW;
                    r_cnt   <= '0;
                    r_out   <= 1'b0;
                end
            endcase
        end
    end

    // Clear has priority over a coincident glitch increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_glitch <= '0;
        end else if (glitch_clr) begin
            r_glitch <= '0;
        end else if (w_glitch_ev) begin
            r_glitch <= sat_inc(r_glitch);
        end
    end

    assign ign_out      = r_out;
    assign ign_rise     = r_rise;
    assign ign_fall     = r_fall;
    assign glitch_count = r_glitch;

endmodule : ign_conditioner
`default_nettype wire
